// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg
//   Shared widths, type-field bit positions, the entry record and the CDB
//   lookup helper for the integer-ALU reservation station.
//   Optional feature macro (used by the top): RS_CDB_BYPASS_EN.
package reservation_station_pkg;

  localparam int ROB_BIT      = 4;   // ROB tag width
  localparam int RS_TYPE_BIT  = 5;   // op-type width
  localparam int RS_SIZE_BIT  = 3;   // log2 of entry count
  localparam int RS_SIZE      = 1 << RS_SIZE_BIT;
  localparam int TYPE_BR_BIT  = 4;   // op type: branch-compare flag
  localparam int TYPE_SUB_BIT = 3;   // op type: sub/sra flag

  typedef logic [ROB_BIT-1:0]     rob_tag_t;
  typedef logic [RS_TYPE_BIT-1:0] rs_type_t;
  typedef logic [RS_SIZE_BIT-1:0] rs_idx_t;

  // One buffered op. rdyN = operand N holds a value; otherwise qN is the
  // producer tag it is waiting on.
  typedef struct packed {
    logic        busy;
    rs_type_t    op;
    logic        rdy1;
    logic        rdy2;
    rob_tag_t    q1;
    rob_tag_t    q2;
    logic [31:0] v1;
    logic [31:0] v2;
    rob_tag_t    rob;
  } rs_entry_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } cdb_hit_t;

  // Look a tag up on both result buses; the ALU bus wins if both match.
  function automatic cdb_hit_t cdb_lookup(
    input rob_tag_t    tag,
    input logic        alu_ready,
    input rob_tag_t    alu_rob_id,
    input logic [31:0] alu_value,
    input logic        lsb_ready,
    input rob_tag_t    lsb_rob_id,
    input logic [31:0] lsb_value
  );
    cdb_hit_t r;
    if (alu_ready && (alu_rob_id == tag)) begin
      r.hit   = 1'b1;
      r.value = alu_value;
    end else if (lsb_ready && (lsb_rob_id == tag)) begin
      r.hit   = 1'b1;
      r.value = lsb_value;
    end else begin
      r.hit   = 1'b0;
      r.value = 32'h0000_0000;
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// reservation_station_if
//   Groups the issue request, both CDB broadcasts, the full flag and the
//   dispatch bundle toward the ALU.
//   slave  : the reservation station (consumes issue/CDB, drives full/exe_*)
//   master : its environment (decoder, CDB producers, ALU)
interface reservation_station_if
  import reservation_station_pkg::*;
  ();

  // issue from decoder
  logic        inst_valid;
  rs_type_t    inst_type;
  logic [31:0] inst_r1;
  logic [31:0] inst_r2;
  logic        inst_has_dep1;
  logic        inst_has_dep2;
  rob_tag_t    inst_dep1;
  rob_tag_t    inst_dep2;
  rob_tag_t    inst_rob_id;
  logic        full;

  // CDB broadcasts
  logic        alu_ready;
  rob_tag_t    alu_rob_id;
  logic [31:0] alu_value;
  logic        lsb_ready;
  rob_tag_t    lsb_rob_id;
  logic [31:0] lsb_value;

  // dispatch to ALU
  logic        exe_valid;
  rs_type_t    exe_type;
  logic [31:0] exe_r1;
  logic [31:0] exe_r2;
  rob_tag_t    exe_rob_id;

  modport slave (
    input  inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1,
           inst_has_dep2, inst_dep1, inst_dep2, inst_rob_id,
    input  alu_ready, alu_rob_id, alu_value,
    input  lsb_ready, lsb_rob_id, lsb_value,
    output full,
    output exe_valid, exe_type, exe_r1, exe_r2, exe_rob_id
  );

  modport master (
    output inst_valid, inst_type, inst_r1, inst_r2, inst_has_dep1,
           inst_has_dep2, inst_dep1, inst_dep2, inst_rob_id,
    output alu_ready, alu_rob_id, alu_value,
    output lsb_ready, lsb_rob_id, lsb_value,
    input  full,
    input  exe_valid, exe_type, exe_r1, exe_r2, exe_rob_id
  );

endinterface

// File: rtl/reservation_station_rs_select.sv
// rs_select
//   Combinational lowest-index priority encoder over the entry vector.
//   req   : one request bit per entry
//   found : at least one request bit set
//   idx   : index of the lowest set bit (0 when none)
module rs_select
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] req,
  output logic               found,
  output rs_idx_t            idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = {RS_SIZE_BIT{1'b0}};
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = rs_idx_t'(i);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station
//   Buffers decoded ALU/branch-compare ops until both operands are known,
//   wakes them from the ALU and LSB result buses, and dispatches one ready
//   op per cycle as a registered bundle toward the ALU.
//   Ports:
//     clk_in  : clock
//     rst_in  : synchronous active-high reset
//     rdy_in  : global enable, low holds all state
//     clear   : mispredict flush (beats issue and dispatch)
//     bus     : issue request, CDB broadcasts, full flag, exe_* dispatch
//   Optional feature: define RS_CDB_BYPASS_EN to let an entry whose last
//   waiting operand is broadcast this cycle dispatch in the same cycle,
//   taking the bus value straight onto exe_r1/exe_r2.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  reservation_station_if.slave  bus
);

  rs_entry_t   ent_q [RS_SIZE];
  rs_entry_t   ent_d [RS_SIZE];
  logic        exe_valid_q,  exe_valid_d;
  rs_type_t    exe_type_q,   exe_type_d;
  logic [31:0] exe_r1_q,     exe_r1_d;
  logic [31:0] exe_r2_q,     exe_r2_d;
  rob_tag_t    exe_rob_id_q, exe_rob_id_d;

  logic [RS_SIZE-1:0] busy_s;
  logic [RS_SIZE-1:0] free_s;
  logic [RS_SIZE-1:0] ready_s;
  cdb_hit_t           wake1_s [RS_SIZE];
  cdb_hit_t           wake2_s [RS_SIZE];
  cdb_hit_t           iss1_s;
  cdb_hit_t           iss2_s;
  rs_entry_t          new_ent_s;
  logic               free_found_s;
  rs_idx_t            free_idx_s;
  logic               sel_found_s;
  rs_idx_t            sel_idx_s;
  logic [31:0]        sel_v1_s;
  logic [31:0]        sel_v2_s;

  // Per-entry CDB match and select eligibility.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_s[i]  = ent_q[i].busy;
      free_s[i]  = ~ent_q[i].busy;
      wake1_s[i] = cdb_lookup(ent_q[i].q1, bus.alu_ready, bus.alu_rob_id,
                              bus.alu_value, bus.lsb_ready, bus.lsb_rob_id,
                              bus.lsb_value);
      wake2_s[i] = cdb_lookup(ent_q[i].q2, bus.alu_ready, bus.alu_rob_id,
                              bus.alu_value, bus.lsb_ready, bus.lsb_rob_id,
                              bus.lsb_value);
`ifdef RS_CDB_BYPASS_EN
      ready_s[i] = ent_q[i].busy
                   && (ent_q[i].rdy1 || wake1_s[i].hit)
                   && (ent_q[i].rdy2 || wake2_s[i].hit);
`else
      ready_s[i] = ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
    end
  end

  rs_select u_free_sel (
    .req   (free_s),
    .found (free_found_s),
    .idx   (free_idx_s)
  );

  rs_select u_ready_sel (
    .req   (ready_s),
    .found (sel_found_s),
    .idx   (sel_idx_s)
  );

  // Operand values of the selected entry (bus value when bypassing).
  always_comb begin
`ifdef RS_CDB_BYPASS_EN
    sel_v1_s = ent_q[sel_idx_s].rdy1 ? ent_q[sel_idx_s].v1 : wake1_s[sel_idx_s].value;
    sel_v2_s = ent_q[sel_idx_s].rdy2 ? ent_q[sel_idx_s].v2 : wake2_s[sel_idx_s].value;
`else
    sel_v1_s = ent_q[sel_idx_s].v1;
    sel_v2_s = ent_q[sel_idx_s].v2;
`endif
  end

  // Build the entry for an incoming op, capturing a same-cycle broadcast.
  always_comb begin
    iss1_s = bus.inst_has_dep1
             ? cdb_lookup(bus.inst_dep1, bus.alu_ready, bus.alu_rob_id,
                          bus.alu_value, bus.lsb_ready, bus.lsb_rob_id,
                          bus.lsb_value)
             : cdb_hit_t'({1'b1, bus.inst_r1});
    iss2_s = bus.inst_has_dep2
             ? cdb_lookup(bus.inst_dep2, bus.alu_ready, bus.alu_rob_id,
                          bus.alu_value, bus.lsb_ready, bus.lsb_rob_id,
                          bus.lsb_value)
             : cdb_hit_t'({1'b1, bus.inst_r2});
    new_ent_s.busy = 1'b1;
    new_ent_s.op   = bus.inst_type;
    new_ent_s.rdy1 = iss1_s.hit;
    new_ent_s.rdy2 = iss2_s.hit;
    new_ent_s.q1   = bus.inst_dep1;
    new_ent_s.q2   = bus.inst_dep2;
    new_ent_s.v1   = iss1_s.value;
    new_ent_s.v2   = iss2_s.value;
    new_ent_s.rob  = bus.inst_rob_id;
  end

  // Next state: flush, else wakeup + dispatch + issue; hold when stalled.
  always_comb begin
    ent_d        = ent_q;
    exe_valid_d  = exe_valid_q;
    exe_type_d   = exe_type_q;
    exe_r1_d     = exe_r1_q;
    exe_r2_d     = exe_r2_q;
    exe_rob_id_d = exe_rob_id_q;
    if (rdy_in && clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = 1'b0;
      end
      exe_valid_d = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy && !ent_q[i].rdy1 && wake1_s[i].hit) begin
          ent_d[i].rdy1 = 1'b1;
          ent_d[i].v1   = wake1_s[i].value;
        end else begin
          ent_d[i].rdy1 = ent_q[i].rdy1;
        end
        if (ent_q[i].busy && !ent_q[i].rdy2 && wake2_s[i].hit) begin
          ent_d[i].rdy2 = 1'b1;
          ent_d[i].v2   = wake2_s[i].value;
        end else begin
          ent_d[i].rdy2 = ent_q[i].rdy2;
        end
      end
      if (sel_found_s) begin
        exe_valid_d           = 1'b1;
        exe_type_d            = ent_q[sel_idx_s].op;
        exe_r1_d              = sel_v1_s;
        exe_r2_d              = sel_v2_s;
        exe_rob_id_d          = ent_q[sel_idx_s].rob;
        ent_d[sel_idx_s].busy = 1'b0;
      end else begin
        exe_valid_d = 1'b0;
      end
      // The free slot comes from the pre-edge busy bits, so it never
      // collides with the entry being dispatched this cycle.
      if (bus.inst_valid && free_found_s) begin
        ent_d[free_idx_s] = new_ent_s;
      end else begin
        ent_d[free_idx_s] = ent_d[free_idx_s];
      end
    end else begin
      exe_valid_d = exe_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= {$bits(rs_entry_t){1'b0}};
      end
      exe_valid_q  <= 1'b0;
      exe_type_q   <= {RS_TYPE_BIT{1'b0}};
      exe_r1_q     <= 32'h0000_0000;
      exe_r2_q     <= 32'h0000_0000;
      exe_rob_id_q <= {ROB_BIT{1'b0}};
    end else begin
      ent_q        <= ent_d;
      exe_valid_q  <= exe_valid_d;
      exe_type_q   <= exe_type_d;
      exe_r1_q     <= exe_r1_d;
      exe_r2_q     <= exe_r2_d;
      exe_rob_id_q <= exe_rob_id_d;
    end
  end

  assign bus.full       = &busy_s;
  assign bus.exe_valid  = exe_valid_q;
  assign bus.exe_type   = exe_type_q;
  assign bus.exe_r1     = exe_r1_q;
  assign bus.exe_r2     = exe_r2_q;
  assign bus.exe_rob_id = exe_rob_id_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
//   Directed bench for reservation_station: reset, independent op,
//   dependency wakeup, same-cycle capture, fill/drain, flush and stall.
//   Expected latencies follow RS_CDB_BYPASS_EN when it is defined.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  reservation_station_if bus ();

  reservation_station dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_exe(input string tag, input logic [31:0] typ, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] rob);
    chk($sformatf("%s.valid", tag), 32'(bus.exe_valid), 32'd1);
    chk($sformatf("%s.type", tag), 32'(bus.exe_type), typ);
    chk($sformatf("%s.r1", tag), bus.exe_r1, r1);
    chk($sformatf("%s.r2", tag), bus.exe_r2, r2);
    chk($sformatf("%s.rob", tag), 32'(bus.exe_rob_id), rob);
  endtask

  task automatic issue(input logic [4:0] typ, input logic [31:0] r1, input logic [31:0] r2,
                       input logic hd1, input logic [3:0] d1, input logic hd2,
                       input logic [3:0] d2, input logic [3:0] rob);
    bus.inst_valid    = 1'b1;
    bus.inst_type     = typ;
    bus.inst_r1       = r1;
    bus.inst_r2       = r2;
    bus.inst_has_dep1 = hd1;
    bus.inst_dep1     = d1;
    bus.inst_has_dep2 = hd2;
    bus.inst_dep2     = d2;
    bus.inst_rob_id   = rob;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    issue(5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    bus.inst_valid = 1'b0;
    bus.alu_ready = 1'b0; bus.alu_rob_id = 4'd0; bus.alu_value = 32'd0;
    bus.lsb_ready = 1'b0; bus.lsb_rob_id = 4'd0; bus.lsb_value = 32'd0;
    tick(); tick();

    // reset state
    chk("rst.valid", 32'(bus.exe_valid), 32'd0);
    chk("rst.type", 32'(bus.exe_type), 32'd0);
    chk("rst.r1", bus.exe_r1, 32'd0);
    chk("rst.r2", bus.exe_r2, 32'd0);
    chk("rst.rob", 32'(bus.exe_rob_id), 32'd0);
    chk("rst.full", 32'(bus.full), 32'd0);
    rst_in = 1'b0;

    // independent add
    issue(5'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    bus.inst_valid = 1'b0;
    chk("ind.issue_edge_valid", 32'(bus.exe_valid), 32'd0);
    tick();
    chk_exe("ind", 32'h0, 32'd5, 32'd7, 32'd3);
    tick();
    chk("ind.pulse_valid", 32'(bus.exe_valid), 32'd0);
    chk("ind.hold_r1", bus.exe_r1, 32'd5);

    // dependency wakeup via ALU bus
    issue(5'h08, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    tick();
    bus.inst_valid = 1'b0;
    tick();
    chk("dep.wait_valid", 32'(bus.exe_valid), 32'd0);
    bus.alu_ready = 1'b1; bus.alu_rob_id = 4'd2; bus.alu_value = 32'h10;
    tick();
    bus.alu_ready = 1'b0;
`ifdef RS_CDB_BYPASS_EN
    chk_exe("dep", 32'h08, 32'h10, 32'd1, 32'd4);
`else
    chk("dep.wake_edge_valid", 32'(bus.exe_valid), 32'd0);
    tick();
    chk_exe("dep", 32'h08, 32'h10, 32'd1, 32'd4);
`endif
    tick();
    chk("dep.pulse_valid", 32'(bus.exe_valid), 32'd0);

    // same-cycle capture from LSB bus
    issue(5'h10, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
    bus.lsb_ready = 1'b1; bus.lsb_rob_id = 4'd6; bus.lsb_value = 32'hAB;
    tick();
    bus.inst_valid = 1'b0; bus.lsb_ready = 1'b0;
    chk("cap.issue_edge_valid", 32'(bus.exe_valid), 32'd0);
    tick();
    chk_exe("cap", 32'h10, 32'd3, 32'hAB, 32'd5);

    // fill all 8 entries waiting on tag 1
    for (int i = 0; i < 8; i++) begin
      issue(5'(i), 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(8 + i));
      tick();
      if (i == 6) chk("fill.not_full_at_7", 32'(bus.full), 32'd0);
    end
    bus.inst_valid = 1'b0;
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.no_dispatch", 32'(bus.exe_valid), 32'd0);
    bus.alu_ready = 1'b1; bus.alu_rob_id = 4'd1; bus.alu_value = 32'h100;
`ifndef RS_CDB_BYPASS_EN
    tick();
    bus.alu_ready = 1'b0;
    chk("drain.wake_valid", 32'(bus.exe_valid), 32'd0);
    chk("drain.wake_full", 32'(bus.full), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.alu_ready = 1'b0;
      chk_exe($sformatf("drain%0d", i), 32'(i), 32'h100, 32'(i), 32'(8 + i));
      chk($sformatf("drain%0d.full", i), 32'(bus.full), 32'd0);
    end
    tick();
    chk("drain.end_valid", 32'(bus.exe_valid), 32'd0);

    // flush with a simultaneous issue
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'(1 + i));
      tick();
    end
    issue(5'd0, 32'h66, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("flush.valid", 32'(bus.exe_valid), 32'd0);
    chk("flush.full", 32'(bus.full), 32'd0);
    issue(5'd0, 32'h55, 32'h56, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    tick();
    bus.inst_valid = 1'b0;
    chk("flush.dropped_issue", 32'(bus.exe_valid), 32'd0);
    tick();
    chk_exe("flush.new", 32'h0, 32'h55, 32'h56, 32'd1);
    bus.alu_ready = 1'b1; bus.alu_rob_id = 4'd9; bus.alu_value = 32'h99;
    tick();
    bus.alu_ready = 1'b0;
    chk("flush.gone1", 32'(bus.exe_valid), 32'd0);
    tick();
    chk("flush.gone2", 32'(bus.exe_valid), 32'd0);

    // stall with ready entry and broadcast pending
    issue(5'd0, 32'd0, 32'd2, 1'b1, 4'd12, 1'b0, 4'd0, 4'd10);
    tick();
    issue(5'd1, 32'h21, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick();
    issue(5'd2, 32'h31, 32'h32, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    bus.inst_valid = 1'b0;
    chk_exe("stall.pre", 32'd1, 32'h21, 32'h22, 32'd2);
    rdy_in = 1'b0;
    bus.alu_ready = 1'b1; bus.alu_rob_id = 4'd12; bus.alu_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_exe($sformatf("stall%0d", i), 32'd1, 32'h21, 32'h22, 32'd2);
    end
    rdy_in = 1'b1;
    bus.alu_ready = 1'b0;
    tick();
    chk_exe("stall.resume", 32'd2, 32'h31, 32'h32, 32'd3);
    tick();
    chk("stall.not_captured", 32'(bus.exe_valid), 32'd0);
    bus.alu_ready = 1'b1;
    tick();
    bus.alu_ready = 1'b0;
`ifdef RS_CDB_BYPASS_EN
    chk_exe("stall.late", 32'd0, 32'h77, 32'd2, 32'd10);
`else
    chk("stall.late_wake_valid", 32'(bus.exe_valid), 32'd0);
    tick();
    chk_exe("stall.late", 32'd0, 32'h77, 32'd2, 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue-side producer for the integer ALU in the Tomasulo core.
- Buffers decoded ALU/branch-compare ops until both operands are known.
- Wakes operands by snooping the CDB (ALU result bus and LSB result bus).
- Dispatches one ready op per cycle as a registered valid/type/r1/r2/rob_id bundle: exactly the input interface the ALU consumes.

Parameters:
- RS_SIZE_BIT, 3, log2 of entry count (RS_SIZE = 8).
- ROB_BIT, 4, ROB tag width; takes the `ROB_BIT value from const.v.
- RS_TYPE_BIT, 5, op-type width; takes the `RS_TYPE_BIT value from const.v. Encoding: bit4 = branch compare, bit3 = sub/sra, bits2:0 = funct3.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low = hold all state
- clear  in  1  mispredict flush
- inst_valid  in  1  issue request from decoder
- inst_type  in  RS_TYPE_BIT  op type
- inst_r1 / inst_r2  in  32  operand values (meaningful when no dependency)
- inst_has_dep1 / inst_has_dep2  in  1  operand waits on ROB tag
- inst_dep1 / inst_dep2  in  ROB_BIT  producer tags
- inst_rob_id  in  ROB_BIT  destination tag
- full  out  1  no free entry (combinational from busy bits)
- alu_ready / alu_rob_id / alu_value  in  1 / ROB_BIT / 32  ALU CDB broadcast
- lsb_ready / lsb_rob_id / lsb_value  in  1 / ROB_BIT / 32  LSB CDB broadcast
- exe_valid  out  1  dispatch to ALU
- exe_type  out  RS_TYPE_BIT
- exe_r1 / exe_r2  out  32
- exe_rob_id  out  ROB_BIT

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset: all busy bits = 0; exe_valid = 0; exe_type = 0; exe_r1 = 0; exe_r2 = 0; exe_rob_id = 0; full = 0.
- Stall: when rdy_in is 0 and rst_in is 0, no state or output changes, including exe_valid.
- Flush: clear = 1 (rdy_in = 1) clears every busy bit and sets exe_valid = 0 at that edge. A simultaneous issue is dropped. clear has priority over issue and dispatch.
- Issue:
  - On inst_valid && !full, write the lowest-index free entry.
  - Per operand: if has_dep is 0, take inst_r; if has_dep is 1 and a CDB bus matches the dep tag this cycle, capture that bus value and mark the operand ready. Otherwise store the tag and mark the operand waiting.
  - inst_valid while full is ignored; the decoder must not assert it.
- Wakeup:
  - Each busy entry compares each waiting tag against both CDB buses every enabled cycle.
  - On a match, latch the value and mark the operand ready.
  - If both buses match the same tag (illegal), alu has priority.
- Select and dispatch:
  - Each enabled cycle, choose the lowest-index busy entry whose two operands are ready at the start of the cycle.
  - Register its fields onto exe_* with exe_valid = 1, and free the entry at the same edge.
  - If no entry is ready, exe_valid = 0 and the other exe_* outputs hold.
- Latency:
  - An entry issued at edge t appears on exe_* after edge t+1 at the earliest.
  - Entries woken at edge t also dispatch after edge t+1 (see the optional feature).
- Simultaneous issue and dispatch: allowed in the same cycle. The freed slot becomes reusable from the next cycle. full reflects busy state after the edge.
- Throughput: at most one dispatch per cycle; exe_valid is a one-cycle pulse per op. The ALU always accepts, so there is no backpressure.
- Boundaries:
  - All 8 busy: full = 1.
  - Dispatch from full: full deasserts after that edge.
  - Tags compare on full ROB_BIT width; there is no wrap handling beyond the ROB's guarantee of unique live tags.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined: an entry whose last waiting operand matches a CDB bus this cycle is eligible for select this cycle. exe_r1 and exe_r2 take the bus value directly, saving 1 cycle of wakeup-to-dispatch.
- Undefined: woken entries become eligible the following cycle only.
- Select priority (lowest index) is unchanged in both cases.

Decomposition:
- Stays in const.v: ROB_BIT, RS_TYPE_BIT.
- Added to const.v: RS_SIZE_BIT and the type-field bit positions (BR flag = 4, SUB/SRA flag = 3).
- Sub-module: rs_select, a combinational lowest-index priority encoder, instantiated twice (free-slot search, ready-slot search). It outputs found and index.

Test Plan:
- Independent op: issue add r1 = 5, r2 = 7, rob 3 at cycle 0 -> exe_valid = 1, type = 0, r1 = 5, r2 = 7, rob_id = 3 after edge 1; exe_valid = 0 the next cycle.
- Dependency wakeup: issue with dep1 = tag 2, r2 = 1; at cycle 4 alu_ready with rob 2, value 0x10 -> dispatch after edge 5 (after edge 4 with RS_CDB_BYPASS_EN) with r1 = 0x10.
- Same-cycle capture: issue with dep2 = 6 while lsb broadcasts rob 6, value 0xAB -> entry stored ready; dispatch next edge with r2 = 0xAB.
- Fill and drain: issue 8 ops all dependent on tag 1 -> full = 1. Broadcast tag 1 -> dispatches in entry order 0..7 on 8 consecutive cycles; full drops after the first dispatch.
- Flush mid-operation: 3 busy entries, assert clear together with inst_valid -> no dispatch follows and full = 0. A new issue next cycle lands in entry 0.
- Stall: hold rdy_in = 0 for 3 cycles while a ready entry and a CDB broadcast are present -> exe_* is frozen and the broadcast is not captured. Resume -> normal dispatch.
